srl_fifo_ctl: RTL and testbench

Controller that turns one external 32x9 adjustable-length SRL shift register into a 33-word, first-word-fall-through FIFO with a valid/pop handshake. It owns the SRL's shift enable and tap address, tracks occupancy, and holds the head word in an output register. It sits between a sample producer and a consumer running on the same clock, for example between a decimator and a serializer.

---
 rtl/srl_fifo_ctl.sv | 110 +++++++++++
 tb/tb_srl_fifo_ctl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/srl_fifo_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : srl_fifo_ctl                                                   |
// | Desc    : Turns an external 32x9 SRL into a 33-word FWFT FIFO with a     |
// |           registered head word. Define SRLFIFO_BYPASS_EN for the         |
// |           empty-FIFO write bypass into the head register.                |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module srl_fifo_ctl #(
  parameter int AF_LEVEL = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] wr_d,
  input  logic       wr_en,
  output logic       full,
  output logic       afull,
  output logic [8:0] rd_d,
  output logic       rd_valid,
  input  logic       rd_en,
  output logic [5:0] level,
  output logic       ovf,
  output logic       udf,
  output logic [8:0] srl_d,
  output logic       srl_ce,
  output logic [4:0] srl_a,
  input  logic [8:0] srl_y
);

  localparam logic [5:0] c_depth    = 6'd32;
  localparam logic [5:0] c_af_level = 6'(AF_LEVEL);

  logic [5:0] r_count;
  logic [8:0] r_rd_d;
  logic       r_rd_valid;
  logic       r_ovf;
  logic       r_udf;

  logic       w_wr_acc;
  logic       w_ld;
  logic       w_pref;
  logic       w_byp;
  logic       w_shift;

  assign full     = (r_count == c_depth);
  assign w_wr_acc = wr_en & ~full;
  assign w_ld     = ~r_rd_valid | rd_en;
  assign w_pref   = w_ld & (r_count != 6'd0);

`ifdef SRLFIFO_BYPASS_EN
  // An empty SRL with a free head register lets the write skip the SRL.
  assign w_byp = w_ld & (r_count == 6'd0) & w_wr_acc;
`else
  assign w_byp = 1'b0;
`endif

  assign w_shift = w_wr_acc & ~w_byp;

  assign srl_d  = wr_d;
  assign srl_ce = w_shift;
  // count==32 wraps to 0 in five bits, so the subtraction still yields 31.
  assign srl_a  = (r_count == 6'd0) ? 5'd0 : (r_count[4:0] - 5'd1);

  assign level    = r_count + {5'd0, r_rd_valid};
  assign afull    = (level >= c_af_level);
  assign rd_d     = r_rd_d;
  assign rd_valid = r_rd_valid;
  assign ovf      = r_ovf;
  assign udf      = r_udf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 6'd0;
    end else begin
      case ({w_shift, w_pref})
        2'b10:   r_count <= r_count + 6'd1;
        2'b01:   r_count <= r_count - 6'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head register: the SRL read at count-1 happens before this edge's shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_d     <= 9'd0;
      r_rd_valid <= 1'b0;
    end else if (w_pref) begin
      r_rd_d     <= srl_y;
      r_rd_valid <= 1'b1;
    end else if (w_byp) begin
      r_rd_d     <= wr_d;
      r_rd_valid <= 1'b1;
    end else if (rd_en) begin
      r_rd_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= r_ovf | (wr_en & full);
      r_udf <= r_udf | (rd_en & ~r_rd_valid);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_srl_fifo_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_srl_fifo_ctl                                                |
// | Desc    : Directed and random bench for srl_fifo_ctl with an SRL model.  |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_srl_fifo_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] wr_d;
  logic       wr_en;
  logic       full;
  logic       afull;
  logic [8:0] rd_d;
  logic       rd_valid;
  logic       rd_en;
  logic [5:0] level;
  logic       ovf;
  logic       udf;
  logic [8:0] srl_d;
  logic       srl_ce;
  logic [4:0] srl_a;
  logic [8:0] srl_y;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] q[$];
  logic [8:0] srl_mem [32];

  always #5 clk = ~clk;

  srl_fifo_ctl #(.AF_LEVEL(28)) dut (
    .clk(clk), .rst(rst), .wr_d(wr_d), .wr_en(wr_en), .full(full),
    .afull(afull), .rd_d(rd_d), .rd_valid(rd_valid), .rd_en(rd_en),
    .level(level), .ovf(ovf), .udf(udf), .srl_d(srl_d), .srl_ce(srl_ce),
    .srl_a(srl_a), .srl_y(srl_y)
  );

  // Behavioural 32x9 adjustable-length shift register.
  always @(posedge clk) begin
    if (srl_ce) begin
      for (int i = 31; i > 0; i--) srl_mem[i] <= srl_mem[i-1];
      srl_mem[0] <= srl_d;
    end
  end
  assign srl_y = srl_mem[srl_a];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Updates the reference queue from pre-edge values, then advances one clock.
  task automatic cycle();
    if (rst) begin
      q.delete();
    end else begin
      if (rd_en && rd_valid) begin
        check_eq("pop_has_data", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) check_eq("pop_order", 32'(rd_d), 32'(q.pop_front()));
      end
      if (wr_en && !full) q.push_back(wr_d);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_d = 9'd0;
    cycle(); cycle();
    rst = 1'b0;
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_rd_d", 32'(rd_d), 32'd0);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_afull", 32'(afull), 32'd0);
    check_eq("rst_flags", 32'({ovf, udf}), 32'd0);

    // Single write into an empty FIFO.
    wr_d = 9'h1A5; wr_en = 1'b1;
    #1;
`ifdef SRLFIFO_BYPASS_EN
    check_eq("single_ce", 32'(srl_ce), 32'd0);
`else
    check_eq("single_ce", 32'(srl_ce), 32'd1);
`endif
    cycle();
    wr_en = 1'b0;
    #1;
    check_eq("single_ce_off", 32'(srl_ce), 32'd0);
    check_eq("single_level_k", 32'(level), 32'd1);
`ifdef SRLFIFO_BYPASS_EN
    check_eq("single_valid_k", 32'(rd_valid), 32'd1);
`else
    check_eq("single_valid_k", 32'(rd_valid), 32'd0);
`endif
    cycle();
    check_eq("single_valid_k1", 32'(rd_valid), 32'd1);
    check_eq("single_rd_d", 32'(rd_d), 32'h1A5);
    check_eq("single_level", 32'(level), 32'd1);
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
    check_eq("single_empty", 32'(level), 32'd0);

    // Fill to 33 words, then overflow.
    wr_en = 1'b1;
    for (int i = 0; i < 33; i++) begin
      wr_d = 9'(i);
      cycle();
      check_eq("fill_level", 32'(level), 32'(i + 1));
      check_eq("fill_afull", 32'(afull), 32'(i + 1 >= 28));
      check_eq("fill_full", 32'(full), 32'(i == 32));
    end
    check_eq("fill_ovf_clear", 32'(ovf), 32'd0);
    wr_d = 9'h055;
    cycle();
    wr_en = 1'b0;
    check_eq("ovf_set", 32'(ovf), 32'd1);
    check_eq("ovf_level", 32'(level), 32'd33);

    // Drain with continuous pops.
    rd_en = 1'b1;
    for (int i = 0; i < 33; i++) begin
      check_eq("drain_valid", 32'(rd_valid), 32'd1);
      check_eq("drain_data", 32'(rd_d), 32'(i));
      cycle();
    end
    check_eq("drain_valid_low", 32'(rd_valid), 32'd0);
    check_eq("drain_udf_clear", 32'(udf), 32'd0);
    cycle();
    rd_en = 1'b0;
    check_eq("udf_set", 32'(udf), 32'd1);
    check_eq("udf_level", 32'(level), 32'd0);

    // Steady write+pop at level 5.
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_d = 9'(9'h100 + i);
      cycle();
    end
    check_eq("stream_start_level", 32'(level), 32'd5);
    rd_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wr_d = 9'(9'h105 + i);
      check_eq("stream_data", 32'(rd_d), 32'(9'(9'h100 + i)));
      cycle();
      check_eq("stream_level", 32'(level), 32'd5);
      check_eq("stream_count", 32'(srl_a), 32'd3);
    end

    // Reset mid-operation at level 20.
    rd_en = 1'b0;
    for (int i = 0; i < 15; i++) begin
      wr_d = 9'(9'h1F0 - i);
      cycle();
    end
    check_eq("pre_rst_level", 32'(level), 32'd20);
    wr_en = 1'b1; rd_en = 1'b1; rst = 1'b1;
    cycle();
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    check_eq("midrst_level", 32'(level), 32'd0);
    check_eq("midrst_valid", 32'(rd_valid), 32'd0);
    check_eq("midrst_full", 32'(full), 32'd0);
    check_eq("midrst_flags", 32'({ovf, udf}), 32'd0);
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_d = 9'(9'h0AA + i);
      cycle();
    end
    wr_en = 1'b0;
    cycle();
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("post_rst_data", 32'(rd_d), 32'(9'(9'h0AA + i)));
      cycle();
    end
    rd_en = 1'b0;
    check_eq("post_rst_empty", 32'(level), 32'd0);

    // Random traffic against the reference queue.
    for (int i = 0; i < 10000; i++) begin
      wr_en = 1'($urandom_range(0, 1));
      rd_en = 1'($urandom_range(0, 1));
      wr_d  = 9'($urandom_range(0, 511));
      cycle();
      check_eq("rand_level", 32'(level), 32'(q.size()));
      check_eq("rand_afull", 32'(afull), 32'(q.size() >= 28));
      if (q.size() == 33) check_eq("rand_full_hi", 32'(full), 32'd1);
      if (q.size() < 32)  check_eq("rand_full_lo", 32'(full), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
